input_conditioner: RTL
======================

# input_conditioner

Parametrised front-end conditioner for the board's raw user inputs (keypad matrix lines, push-buttons, the pill sensor). It synchronises every channel into the clock domain, debounces each channel independently and produces a clean level plus single-cycle press, release and auto-repeat pulses. It sits between the top-level pins and the controller FSM, which consumes only the pulses and levels.

## Interface
- WIDTH, 16: number of independent input channels (≥1).
- SYNC_STAGES, 2: synchroniser flops per channel (≥2).
- DEBOUNCE_CYCLES, 4: consecutive mismatching cycles required before the debounced level flips (≥1; 1 gives plain sync plus edge detect).
- HOLD_CYCLES, 10: cycles after press before the first repeat pulse. 0 disables repeat.
- REPEAT_CYCLES, 3: period of subsequent repeat pulses (≥1).
- clock  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- raw  in  WIDTH  asynchronous raw inputs; idle level is 0.
- level  out  WIDTH  debounced level per channel.
- press  out  WIDTH  one-cycle pulse when level rises.
- release  out  WIDTH  one-cycle pulse when level falls.
- repeat  out  WIDTH  one-cycle auto-repeat pulse while held.

## Operation
- Per channel: SYNC_STAGES-deep shift register → debounce counter → hold/repeat FSM. Channels share nothing.
- Debounce: s = last sync stage. If s == level, counter clears to 0. If s != level and counter < DEBOUNCE_CYCLES-1, counter increments. If s != level and counter == DEBOUNCE_CYCLES-1, level <= s, counter clears, and press (rising) or release (falling) is asserted for that one cycle.
- Counter width: $clog2(DEBOUNCE_CYCLES)+1. The counter never wraps.
- Hold FSM states: IDLE, PRESSED, HELD.
  - IDLE → PRESSED on the level rise. hold_cnt clears.
  - PRESSED: hold_cnt increments each cycle. When HOLD_CYCLES cycles have elapsed since the press, assert repeat, go to HELD and clear rep_cnt.
  - HELD: when REPEAT_CYCLES cycles have elapsed since the last repeat, assert repeat again and clear rep_cnt.
  - Any state → IDLE on the level fall, with no repeat in that cycle.
  - With HOLD_CYCLES == 0, the FSM stays in PRESSED and never repeats.
- press and repeat are never asserted in the same cycle. release and repeat are never asserted in the same cycle.
- All outputs are registered. There are no combinational paths from raw.

## Timing
- Reset (asynchronous, immediate): sync flops, counters, level, press, release and repeat all go to 0. FSM goes to IDLE.
- Press latency: raw changes before edge 1 and stays stable, so level rises and press pulses after edge SYNC_STAGES+DEBOUNCE_CYCLES (6 with defaults). Release latency is symmetric.
- Any pulse on s shorter than DEBOUNCE_CYCLES cycles produces no output change.
- Reset mid-operation: no release pulse is emitted. If raw is still high after reset_n rises, a fresh press follows after SYNC_STAGES+DEBOUNCE_CYCLES cycles.
- Counters saturate and hold while idle. There is no wrap-around in a long hold; rep_cnt reloads on each repeat.
- Simultaneous events on different channels produce pulses in the same cycle.

## Structure
- Shared package input_pkg holds:
  - typedef enum hold_state_t {IDLE, PRESSED, HELD};
  - the counter-width helper function.
- Sub-module input_conditioner_channel contains one channel (sync, debounce, FSM) with the same parameters and scalar ports. The top level is a generate loop over WIDTH.

## Test plan
All scenarios use defaults except WIDTH=4.
- Reset: hold reset_n low with raw=4'hF → level, press, release and repeat all 0. Release reset → press on all channels at edge 6.
- Clean press: raw[0] rises before edge 1 and stays high → level[0]=1 from edge 6, press[0] only at edge 6, repeat[0] at edges 16, 19, 22. raw[0] falls → release[0] 6 cycles later, no further repeat.
- Glitch rejection: raw[1] high for exactly 3 cycles → no press, level stays 0. With 4 stable cycles → press.
- Bounce: raw[2] toggles every 2 cycles for 20 cycles then stays high → exactly one press[2], 6 cycles after the last toggle.
- Simultaneous: raw[3:2] rise together while ch0 is HELD → press[3] and press[2] in the same cycle, ch0 repeat cadence unaffected.
- Reset mid-hold: assert reset_n during HELD → outputs 0 immediately, no release. After release of reset with raw still high → press again at edge 6.

Source files
------------

// File: rtl/input_pkg.sv
// Shared types and helpers for the input conditioner: hold FSM states and
// the counter-width rule used by every per-channel counter.
package input_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      HELD    = 2'd2
   } hold_state_t;

   localparam int STATE_W = 2;

   // One spare bit above $clog2 so a terminal count of exactly n is representable.
   function automatic int cnt_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Pin-side bundle of the conditioner: raw inputs in, debounced levels and
// pulses out, plus the packed per-channel hold FSM state for observation.
interface input_conditioner_if #(
   parameter int WIDTH = 16
);

   logic [WIDTH-1:0]                        i_raw;
   logic [WIDTH-1:0]                        o_level;
   logic [WIDTH-1:0]                        o_press;
   logic [WIDTH-1:0]                        o_release;
   logic [WIDTH-1:0]                        o_repeat;
   logic [input_pkg::STATE_W*WIDTH-1:0]     o_dbg_state;

   modport master (
      output i_raw,
      input  o_level, o_press, o_release, o_repeat, o_dbg_state
   );

   modport slave (
      input  i_raw,
      output o_level, o_press, o_release, o_repeat, o_dbg_state
   );

endinterface

// File: rtl/input_conditioner_channel.sv
// One input channel: synchroniser, debounce counter and hold/repeat FSM.
// Every output is a flop; nothing combinational reaches the pins from i_raw.
module input_conditioner_channel
   import input_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int HOLD_CYCLES     = 10,
   parameter int REPEAT_CYCLES   = 3
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        i_raw,
   output logic        o_level,
   output logic        o_press,
   output logic        o_release,
   output logic        o_repeat,
   output hold_state_t o_state
);

   localparam int DW = cnt_width(DEBOUNCE_CYCLES);
   localparam int HW = cnt_width(HOLD_CYCLES);
   localparam int RW = cnt_width(REPEAT_CYCLES);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = (HOLD_CYCLES > 0) ? HW'(HOLD_CYCLES - 1) : '0;
   localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [DW-1:0]          r_deb_cnt;
   logic                   r_level;
   logic                   r_press;
   logic                   r_release;
   logic                   r_repeat;
   hold_state_t            r_state;
   hold_state_t            w_state_next;
   logic [HW-1:0]          r_hold_cnt;
   logic [HW-1:0]          w_hold_cnt_next;
   logic [RW-1:0]          r_rep_cnt;
   logic [RW-1:0]          w_rep_cnt_next;
   logic                   w_sync;
   logic                   w_flip;
   logic                   w_rise;
   logic                   w_fall;
   logic                   w_repeat;

   assign w_sync = r_sync[SYNC_STAGES-1];
   assign w_flip = (w_sync != r_level) && (r_deb_cnt == DEB_LAST);
   assign w_rise = w_flip && w_sync;
   assign w_fall = w_flip && !w_sync;

   // The FSM reacts to the flip in the same cycle the level register updates,
   // so press/release and the state change line up on one edge.
   always_comb begin
      w_state_next    = r_state;
      w_hold_cnt_next = r_hold_cnt;
      w_rep_cnt_next  = r_rep_cnt;
      w_repeat        = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_rise) begin
               w_state_next    = PRESSED;
               w_hold_cnt_next = '0;
            end
         end
         PRESSED: begin
            if (w_fall) begin
               w_state_next = IDLE;
            end else if (HOLD_CYCLES > 0) begin
               if (r_hold_cnt == HOLD_LAST) begin
                  w_repeat       = 1'b1;
                  w_state_next   = HELD;
                  w_rep_cnt_next = '0;
               end else begin
                  w_hold_cnt_next = r_hold_cnt + 1'b1;
               end
            end
         end
         HELD: begin
            if (w_fall) begin
               w_state_next = IDLE;
            end else if (r_rep_cnt == REP_LAST) begin
               w_repeat       = 1'b1;
               w_rep_cnt_next = '0;
            end else begin
               w_rep_cnt_next = r_rep_cnt + 1'b1;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sync     <= '0;
         r_deb_cnt  <= '0;
         r_level    <= 1'b0;
         r_press    <= 1'b0;
         r_release  <= 1'b0;
         r_repeat   <= 1'b0;
         r_state    <= IDLE;
         r_hold_cnt <= '0;
         r_rep_cnt  <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
         if (w_sync == r_level) begin
            r_deb_cnt <= '0;
         end else if (w_flip) begin
            r_deb_cnt <= '0;
            r_level   <= w_sync;
         end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
         end
         r_press    <= w_rise;
         r_release  <= w_fall;
         r_repeat   <= w_repeat;
         r_state    <= w_state_next;
         r_hold_cnt <= w_hold_cnt_next;
         r_rep_cnt  <= w_rep_cnt_next;
      end
   end

   assign o_level   = r_level;
   assign o_press   = r_press;
   assign o_release = r_release;
   assign o_repeat  = r_repeat;
   assign o_state   = r_state;

endmodule

// File: rtl/input_conditioner.sv
// Front-end conditioner for raw board inputs: WIDTH fully independent
// channels, each synchronised, debounced and given press/release/repeat pulses.
module input_conditioner
   import input_pkg::*;
#(
   parameter int WIDTH           = 16,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int HOLD_CYCLES     = 10,
   parameter int REPEAT_CYCLES   = 3
) (
   input  logic                clock,
   input  logic                reset_n,
   input_conditioner_if.slave  bus
);

   logic [WIDTH-1:0]         w_level;
   logic [WIDTH-1:0]         w_press;
   logic [WIDTH-1:0]         w_release;
   logic [WIDTH-1:0]         w_repeat;
   logic [STATE_W*WIDTH-1:0] w_state;

   for (genvar g = 0; g < WIDTH; g++) begin : g_chan
      hold_state_t w_ch_state;

      input_conditioner_channel #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .HOLD_CYCLES     (HOLD_CYCLES),
         .REPEAT_CYCLES   (REPEAT_CYCLES)
      ) u_chan (
         .clock     (clock),
         .reset_n   (reset_n),
         .i_raw     (bus.i_raw[g]),
         .o_level   (w_level[g]),
         .o_press   (w_press[g]),
         .o_release (w_release[g]),
         .o_repeat  (w_repeat[g]),
         .o_state   (w_ch_state)
      );

      assign w_state[g*STATE_W +: STATE_W] = w_ch_state;
   end

   assign bus.o_level     = w_level;
   assign bus.o_press     = w_press;
   assign bus.o_release   = w_release;
   assign bus.o_repeat    = w_repeat;
   assign bus.o_dbg_state = w_state;

endmodule
